// File: rtl/simple_processor_pkg.sv
// Shared types and encodings for the simple processor decode path: operation
// enum, opcode constants, instruction field positions and the skid FSM states.
package simple_processor_pkg;

  typedef enum logic [3:0] {
    FUNC_AND  = 4'd0,
    FUNC_OR   = 4'd1,
    FUNC_XOR  = 4'd2,
    FUNC_NOT  = 4'd3,
    FUNC_ADDI = 4'd4,
    FUNC_ADD  = 4'd5,
    FUNC_SUB  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SLLI = 4'd8;
  localparam logic [3:0] OP_SLR  = 4'd9;
  localparam logic [3:0] OP_SLRI = 4'd10;

  // Opcodes 11..15 have no operation assigned.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RS1_MSB    = 8;
  localparam int RS1_LSB    = 6;
  localparam int RS2_MSB    = 5;
  localparam int RS2_LSB    = 3;
  localparam int IMM_MSB    = 5;
  localparam int IMM_LSB    = 0;

  typedef struct packed {
    func_t       func;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        we;
    logic        illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational decode of one 16-bit instruction word into the
// execution bundle; undefined opcodes produce an inert, flagged bundle.
module instr_field_decode
  import simple_processor_pkg::*;
(
  input  logic [15:0] instr,
  output decoded_t    dec
);

  logic [3:0] opcode;

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    dec = '0;
    if (opcode >= OP_ILLEGAL_MIN) begin
      dec.illegal = 1'b1;
      dec.func    = FUNC_AND;
    end else begin
      dec.func = func_t'(opcode);
      dec.we   = 1'b1;
      dec.rd   = instr[RD_MSB:RD_LSB];
      dec.rs1  = instr[RS1_MSB:RS1_LSB];
      case (opcode)
        OP_ADDI, OP_SLLI, OP_SLRI: begin
          dec.imm     = {{26{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
          dec.use_imm = 1'b1;
        end
        OP_NOT: ;
        default: dec.rs2 = instr[RS2_MSB:RS2_LSB];
      endcase
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder with a two-entry skid buffer between fetch and execute.
// Optional feature: define ILLEGAL_CNT_EN for a saturating illegal-op counter.
module instr_decoder
  import simple_processor_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output func_t       func_o,
  output logic [2:0]  rd_addr_o,
  output logic [2:0]  rs1_addr_o,
  output logic [2:0]  rs2_addr_o,
  output logic [31:0] imm_o,
  output logic        use_imm_o,
  output logic        we_o,
  output logic        illegal_o,
  output logic [7:0]  illegal_cnt_o
);

  skid_state_t state_q, state_d;
  decoded_t    main_q, main_d;
  decoded_t    skid_q, skid_d;
  decoded_t    dec;
  logic        ready_q, ready_d;
  logic        accept;

  instr_field_decode u_field_decode (
    .instr (instr_i),
    .dec   (dec)
  );

  assign accept = instr_valid_i & ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Ready is registered from the next state so ready_i never reaches instr_ready_o.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept && ready_i) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = S_FULL;
        end else if (ready_i) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (ready_i) begin
          main_d  = skid_q;
          state_d = S_BUSY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    ready_d = (state_d != S_FULL);
  end

  assign instr_ready_o = ready_q;
  assign valid_o       = (state_q != S_EMPTY);
  assign func_o        = main_q.func;
  assign rd_addr_o     = main_q.rd;
  assign rs1_addr_o    = main_q.rs1;
  assign rs2_addr_o    = main_q.rs2;
  assign imm_o         = main_q.imm;
  assign use_imm_o     = main_q.use_imm;
  assign we_o          = main_q.we;
  assign illegal_o     = main_q.illegal;

`ifdef ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_cnt_q <= '0;
    end else if (accept && dec.illegal && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign illegal_cnt_o = illegal_cnt_q;
`else
  assign illegal_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed decode, skid, illegal and
// reset scenarios followed by a randomly throttled legal instruction stream.
module tb_instr_decoder;
  import simple_processor_pkg::*;

  typedef struct packed {
    logic [3:0]  func;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        we;
    logic        illegal;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        valid_o;
  logic        ready_i;
  func_t       func_o;
  logic [2:0]  rd_addr_o;
  logic [2:0]  rs1_addr_o;
  logic [2:0]  rs2_addr_o;
  logic [31:0] imm_o;
  logic        use_imm_o;
  logic        we_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt_o;

  int errors = 0;
  int checks = 0;

  instr_decoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .func_o        (func_o),
    .rd_addr_o     (rd_addr_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .imm_o         (imm_o),
    .use_imm_o     (use_imm_o),
    .we_o          (we_o),
    .illegal_o     (illegal_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference decode written straight from the opcode table.
  function automatic exp_t ref_decode(input logic [15:0] w);
    exp_t e;
    logic [3:0] op;
    e  = '0;
    op = w[15:12];
    if (op > 4'd10) begin
      e.illegal = 1'b1;
      return e;
    end
    e.func = op;
    e.we   = 1'b1;
    e.rd   = w[11:9];
    e.rs1  = w[8:6];
    if (op == 4'd4 || op == 4'd8 || op == 4'd10) begin
      e.imm     = {{26{w[5]}}, w[5:0]};
      e.use_imm = 1'b1;
    end else if (op != 4'd3) begin
      e.rs2 = w[5:3];
    end
    return e;
  endfunction

  function automatic exp_t observe();
    return {4'(func_o), rd_addr_o, rs1_addr_o, rs2_addr_o, imm_o, use_imm_o, we_o, illegal_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    instr_i = 16'h5298;
    instr_valid_i = 1'b1;
    ready_i = 1'b1;
    tick();
    tick();
    instr_valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", instr_ready_o); end
    checks++; if (observe() !== exp_t'(0)) begin errors++; $display("[TB] FAIL reset_bundle got=%h exp=0", observe()); end
    checks++; if (illegal_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", illegal_cnt_o); end
    rst_i = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_add();
    do_reset();
    ready_i = 1'b1;
    instr_i = 16'h5298;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got=%b exp=1", valid_o); end
    checks++; if (func_o !== FUNC_ADD) begin errors++; $display("[TB] FAIL add_func got=%0d exp=5", func_o); end
    checks++; if (rd_addr_o !== 3'd1) begin errors++; $display("[TB] FAIL add_rd got=%0d exp=1", rd_addr_o); end
    checks++; if (rs1_addr_o !== 3'd2) begin errors++; $display("[TB] FAIL add_rs1 got=%0d exp=2", rs1_addr_o); end
    checks++; if (rs2_addr_o !== 3'd3) begin errors++; $display("[TB] FAIL add_rs2 got=%0d exp=3", rs2_addr_o); end
    checks++; if (use_imm_o !== 1'b0 || imm_o !== 32'd0) begin errors++; $display("[TB] FAIL add_imm got=%b/%h exp=0/0", use_imm_o, imm_o); end
    checks++; if (we_o !== 1'b1 || illegal_o !== 1'b0) begin errors++; $display("[TB] FAIL add_we got=%b/%b exp=1/0", we_o, illegal_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL add_drain got=%b exp=0", valid_o); end
  endtask

  task automatic test_addi();
    do_reset();
    ready_i = 1'b1;
    instr_i = 16'h4E7F;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    checks++; if (func_o !== FUNC_ADDI) begin errors++; $display("[TB] FAIL addi_func got=%0d exp=4", func_o); end
    checks++; if (imm_o !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL addi_imm got=%h exp=ffffffff", imm_o); end
    checks++; if (use_imm_o !== 1'b1) begin errors++; $display("[TB] FAIL addi_use_imm got=%b exp=1", use_imm_o); end
    checks++; if (rd_addr_o !== 3'd7 || rs1_addr_o !== 3'd1) begin errors++; $display("[TB] FAIL addi_regs got=%0d/%0d exp=7/1", rd_addr_o, rs1_addr_o); end
    checks++; if (rs2_addr_o !== 3'd0) begin errors++; $display("[TB] FAIL addi_rs2 got=%0d exp=0", rs2_addr_o); end
    // NOT ignores rs2 and immediate fields entirely.
    instr_i = 16'h3A7F;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    checks++; if (observe() !== {4'd3, 3'd5, 3'd1, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL not_bundle got=%h", observe()); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_i = 1'b0;
    instr_i = 16'h5298;
    instr_valid_i = 1'b1;
    tick();
    checks++; if (func_o !== FUNC_ADD || valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first got=%0d/%b exp=5/1", func_o, valid_o); end
    instr_i = 16'h4E7F;
    tick();
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready got=%b exp=0", instr_ready_o); end
    instr_i = 16'h1000;
    tick();
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_third_held got=%b exp=0", instr_ready_o); end
    checks++; if (func_o !== FUNC_ADD || rd_addr_o !== 3'd1) begin errors++; $display("[TB] FAIL b2b_stable got=%0d/%0d exp=5/1", func_o, rd_addr_o); end
    ready_i = 1'b1;
    tick();
    checks++; if (func_o !== FUNC_ADDI || rd_addr_o !== 3'd7 || valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second got=%0d/%0d exp=4/7", func_o, rd_addr_o); end
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_back got=%b exp=1", instr_ready_o); end
    tick();
    instr_valid_i = 1'b0;
    checks++; if (func_o !== FUNC_OR || rd_addr_o !== 3'd0 || valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_third got=%0d/%0d exp=1/0", func_o, rd_addr_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty got=%b exp=0", valid_o); end
  endtask

  task automatic test_illegal();
    logic [7:0] exp_cnt1, exp_cnt2;
`ifdef ILLEGAL_CNT_EN
    exp_cnt1 = 8'd1;
    exp_cnt2 = 8'd2;
`else
    exp_cnt1 = 8'd0;
    exp_cnt2 = 8'd0;
`endif
    do_reset();
    ready_i = 1'b1;
    instr_i = 16'hF000;
    instr_valid_i = 1'b1;
    tick();
    checks++; if (illegal_o !== 1'b1 || we_o !== 1'b0) begin errors++; $display("[TB] FAIL ill_flags got=%b/%b exp=1/0", illegal_o, we_o); end
    checks++; if (illegal_cnt_o !== exp_cnt1) begin errors++; $display("[TB] FAIL ill_cnt1 got=%0d exp=%0d", illegal_cnt_o, exp_cnt1); end
    instr_i = 16'hFFFF;
    tick();
    instr_valid_i = 1'b0;
    checks++; if (observe() !== {4'd0, 3'd0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL ill_bundle got=%h", observe()); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ill_valid got=%b exp=1", valid_o); end
    checks++; if (illegal_cnt_o !== exp_cnt2) begin errors++; $display("[TB] FAIL ill_cnt2 got=%0d exp=%0d", illegal_cnt_o, exp_cnt2); end
    tick();
    checks++; if (illegal_cnt_o !== exp_cnt2) begin errors++; $display("[TB] FAIL ill_cnt_hold got=%0d exp=%0d", illegal_cnt_o, exp_cnt2); end
  endtask

  task automatic test_reset_full();
    do_reset();
    ready_i = 1'b0;
    instr_i = 16'h5298;
    instr_valid_i = 1'b1;
    tick();
    instr_i = 16'h4E7F;
    tick();
    checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_full got=%b exp=0", instr_ready_o); end
    rst_i = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0 || instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rf_reset got=%b/%b exp=0/1", valid_o, instr_ready_o); end
    checks++; if (observe() !== exp_t'(0)) begin errors++; $display("[TB] FAIL rf_bundle got=%h exp=0", observe()); end
    rst_i = 1'b0;
    instr_valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rf_stale cycle=%0d got=%b exp=0", i, valid_o); end
    end
  endtask

  task automatic test_random_stream();
    exp_t        q[$];
    exp_t        held, got, want;
    logic        hold;
    logic [15:0] pending;
    int          sent, recv, cyc;
    do_reset();
    sent = 0;
    recv = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    pending = {4'($urandom_range(0, 10)), 12'($urandom)};
    while (recv < 100 && cyc < 3000) begin
      instr_valid_i = (sent < 100) && ($urandom_range(0, 3) != 0);
      instr_i = pending;
      ready_i = ($urandom_range(0, 2) != 0);
      if (valid_o && ready_i) begin
        got = observe();
        checks++;
        if (q.size() == 0) begin
          errors++; $display("[TB] FAIL stream_extra idx=%0d got=%h", recv, got);
        end else begin
          want = q.pop_front();
          if (got !== want) begin errors++; $display("[TB] FAIL stream_data idx=%0d got=%h exp=%h", recv, got, want); end
        end
        recv++;
      end
      if (instr_valid_i && instr_ready_o) begin
        q.push_back(ref_decode(pending));
        sent++;
        pending = {4'($urandom_range(0, 10)), 12'($urandom)};
      end
      hold = valid_o && !ready_i;
      held = observe();
      tick();
      cyc++;
      if (hold) begin
        checks++; if (observe() !== held || valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stream_stable cyc=%0d got=%h exp=%h", cyc, observe(), held); end
      end
    end
    instr_valid_i = 1'b0;
    ready_i = 1'b1;
    checks++; if (recv != 100) begin errors++; $display("[TB] FAIL stream_count got=%0d exp=100", recv); end
    tick();
    checks++; if (valid_o !== 1'b0 || q.size() != 0) begin errors++; $display("[TB] FAIL stream_leftover valid=%b queued=%0d exp=0/0", valid_o, q.size()); end
  endtask

  initial begin
    rst_i = 1'b1;
    instr_i = '0;
    instr_valid_i = 1'b0;
    ready_i = 1'b0;
    test_reset();
    test_add();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_reset_full();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
